cohort_txn_queue: RTL and testbench

//  Parametrised in-order buffer for load/store transactions from the Cohort engine to the

---
 rtl/cohort_txn_queue_if.sv | 42 ++++
 rtl/cohort_txn_queue.sv | 97 +++++++++
 tb/tb_cohort_txn_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cohort_txn_queue_if.sv
// Handshake bundle between the Cohort engine, the transaction queue and the memory side.
// The queue attaches through the slave modport; the producer/consumer side uses master.
interface cohort_txn_queue_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 40,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              in_type_i;
  logic [ADDR_W-1:0] in_addr_i;
  logic [2:0]        in_size_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              out_type_o;
  logic [ADDR_W-1:0] out_addr_o;
  logic [2:0]        out_size_o;
  logic [DATA_W-1:0] out_data_o;
  logic [CW-1:0]     count_o;
  logic              almost_full_o;
  logic              err_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic              err_clr_i;

  modport slave (
    input  flush_i, in_valid_i, in_type_i, in_addr_i, in_size_i, in_data_i,
           out_ready_i, err_clr_i,
    output in_ready_o, out_valid_o, out_type_o, out_addr_o, out_size_o, out_data_o,
           count_o, almost_full_o, err_o, err_addr_o
  );

  modport master (
    output flush_i, in_valid_i, in_type_i, in_addr_i, in_size_i, in_data_i,
           out_ready_i, err_clr_i,
    input  in_ready_o, out_valid_o, out_type_o, out_addr_o, out_size_o, out_data_o,
           count_o, almost_full_o, err_o, err_addr_o
  );
endinterface

// File: rtl/cohort_txn_queue.sv
// In-order load/store buffer from the Cohort engine to memory. Misaligned or oversized
// transactions are accepted but dropped, with a sticky error and the first bad address logged.
module cohort_txn_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 40,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cohort_txn_queue_if.slave     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] MAXSZ = 3'($clog2(DATA_W / 8));

  logic              memType_q [DEPTH];
  logic [ADDR_W-1:0] memAddr_q [DEPTH];
  logic [2:0]        memSize_q [DEPTH];
  logic [DATA_W-1:0] memData_q [DEPTH];

  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] errAddr_q, errAddr_d;

  logic              push, pop, legal, legalPush;
  logic [ADDR_W-1:0] alignMask;

  assign alignMask = ~({ADDR_W{1'b1}} << bus.in_size_i);
  assign legal     = (bus.in_size_i <= MAXSZ) && ((bus.in_addr_i & alignMask) == '0);

  assign bus.in_ready_o  = (count_q != CW'(DEPTH)) && !bus.flush_i;
  assign bus.out_valid_o = (count_q != '0);
  assign push            = bus.in_valid_i && bus.in_ready_o;
  assign pop             = bus.out_valid_o && bus.out_ready_i;
  assign legalPush       = push && legal;

  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    err_d     = err_q;
    errAddr_d = errAddr_q;
    if (bus.flush_i) begin
      count_d = '0;
      rdPtr_d = wrPtr_q;
    end else begin
      if (legalPush) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)       rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(legalPush) - CW'(pop);
    end
    // A new error beats a same-cycle clear, and then the new address is the one kept.
    if (push && !legal) begin
      err_d = 1'b1;
      if (!err_q || bus.err_clr_i) errAddr_d = bus.in_addr_i;
    end else if (bus.err_clr_i) begin
      err_d     = 1'b0;
      errAddr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      errAddr_q <= '0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (legalPush) begin
      memType_q[wrPtr_q] <= bus.in_type_i;
      memAddr_q[wrPtr_q] <= bus.in_addr_i;
      memSize_q[wrPtr_q] <= bus.in_size_i;
      memData_q[wrPtr_q] <= bus.in_type_i ? bus.in_data_i : '0;
    end
  end

  assign bus.out_type_o    = memType_q[rdPtr_q];
  assign bus.out_addr_o    = memAddr_q[rdPtr_q];
  assign bus.out_size_o    = memSize_q[rdPtr_q];
  assign bus.out_data_o    = memData_q[rdPtr_q];
  assign bus.count_o       = count_q;
  assign bus.almost_full_o = (count_q >= CW'(AF_LVL));
  assign bus.err_o         = err_q;
  assign bus.err_addr_o    = errAddr_q;
endmodule

// File: tb/tb_cohort_txn_queue.sv
// Directed bench for cohort_txn_queue: fill/drain, legality errors, load data zeroing,
// simultaneous push/pop with pointer wrap, flush and asynchronous reset.
module tb_cohort_txn_queue;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 40;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;

  logic clk_i;
  logic rst_ni;
  int   checkCount;
  int   failCount;

  cohort_txn_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  cohort_txn_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic typ, input logic [39:0] addr,
                               input logic [2:0] size, input logic [63:0] data);
    bus.in_valid_i = valid;
    bus.in_type_i  = typ;
    bus.in_addr_i  = addr;
    bus.in_size_i  = size;
    bus.in_data_i  = data;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  logic [39:0] headTable [6];

  initial begin
    checkCount = 0;
    failCount  = 0;
    headTable[0] = 40'h40;  headTable[1] = 40'h41;  headTable[2] = 40'h200;
    headTable[3] = 40'h208; headTable[4] = 40'h210; headTable[5] = 40'h218;
    rst_ni          = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.err_clr_i   = 1'b0;
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    #23;
    checkOutput("rst_count", 64'(bus.count_o), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("rst_err", 64'(bus.err_o), 64'd0);
    checkOutput("rst_err_addr", 64'(bus.err_addr_o), 64'd0);
    rst_ni = 1'b1;
    stepCycle();
    checkOutput("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

    $display("[TB] test 1: fill with four stores");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 40'h100 + 40'(8 * i), 3'd3, 64'hA000 + 64'(i));
      stepCycle();
      checkOutput($sformatf("t1_count%0d", i), 64'(bus.count_o), 64'(i + 1));
      checkOutput($sformatf("t1_af%0d", i), 64'(bus.almost_full_o), 64'(i + 1 >= 3));
      checkOutput($sformatf("t1_ready%0d", i), 64'(bus.in_ready_o), 64'(i + 1 != 4));
    end
    applyStimulus(1'b1, 1'b1, 40'h900, 3'd3, 64'h0);
    stepCycle();
    checkOutput("t1_full_hold", 64'(bus.count_o), 64'd4);
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);

    $display("[TB] test 2: drain in order");
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_valid%0d", i), 64'(bus.out_valid_o), 64'd1);
      checkOutput($sformatf("t2_addr%0d", i), 64'(bus.out_addr_o), 64'h100 + 64'(8 * i));
      checkOutput($sformatf("t2_data%0d", i), bus.out_data_o, 64'hA000 + 64'(i));
      stepCycle();
    end
    checkOutput("t2_empty", 64'(bus.out_valid_o), 64'd0);
    bus.out_ready_i = 1'b0;

    $display("[TB] test 3: misaligned drops and error log");
    applyStimulus(1'b1, 1'b0, 40'h104, 3'd3, 64'h0);
    stepCycle();
    checkOutput("t3_count", 64'(bus.count_o), 64'd0);
    checkOutput("t3_err", 64'(bus.err_o), 64'd1);
    checkOutput("t3_err_addr", 64'(bus.err_addr_o), 64'h104);
    applyStimulus(1'b1, 1'b0, 40'h20A, 3'd2, 64'h0);
    stepCycle();
    checkOutput("t3_err_addr_kept", 64'(bus.err_addr_o), 64'h104);
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    bus.err_clr_i = 1'b1;
    stepCycle();
    checkOutput("t3_clr_err", 64'(bus.err_o), 64'd0);
    checkOutput("t3_clr_addr", 64'(bus.err_addr_o), 64'd0);
    bus.err_clr_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 40'h301, 3'd1, 64'h0);
    stepCycle();
    checkOutput("t3_err2_addr", 64'(bus.err_addr_o), 64'h301);
    bus.err_clr_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 40'h303, 3'd1, 64'h0);
    stepCycle();
    checkOutput("t3_setwins_err", 64'(bus.err_o), 64'd1);
    checkOutput("t3_setwins_addr", 64'(bus.err_addr_o), 64'h303);
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    stepCycle();
    bus.err_clr_i = 1'b0;

    $display("[TB] test 4: oversize drop and load data zeroing");
    applyStimulus(1'b1, 1'b1, 40'h0, 3'd4, 64'h1234);
    stepCycle();
    checkOutput("t4_size_err", 64'(bus.err_o), 64'd1);
    checkOutput("t4_size_count", 64'(bus.count_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    bus.err_clr_i = 1'b1;
    stepCycle();
    bus.err_clr_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 40'h40, 3'd3, 64'hDEAD);
    stepCycle();
    checkOutput("t4_load_count", 64'(bus.count_o), 64'd1);
    checkOutput("t4_load_addr", 64'(bus.out_addr_o), 64'h40);
    checkOutput("t4_load_type", 64'(bus.out_type_o), 64'd0);
    checkOutput("t4_load_data", bus.out_data_o, 64'd0);
    applyStimulus(1'b1, 1'b1, 40'h41, 3'd0, 64'h5A);
    stepCycle();
    checkOutput("t4_size0_count", 64'(bus.count_o), 64'd2);
    checkOutput("t4_size0_err", 64'(bus.err_o), 64'd0);

    $display("[TB] test 5: steady push and pop with wrap");
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, 40'h200 + 40'(8 * k), 3'd3, 64'(k));
      checkOutput($sformatf("t5_head%0d", k), 64'(bus.out_addr_o), 64'(headTable[k]));
      if (k == 1) checkOutput("t5_data41", bus.out_data_o, 64'h5A);
      stepCycle();
      checkOutput($sformatf("t5_count%0d", k), 64'(bus.count_o), 64'd2);
    end
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    checkOutput("t5_tail0", 64'(bus.out_addr_o), 64'h220);
    stepCycle();
    checkOutput("t5_tail1", 64'(bus.out_addr_o), 64'h228);
    checkOutput("t5_tail1_data", bus.out_data_o, 64'd5);
    stepCycle();
    checkOutput("t5_drained", 64'(bus.count_o), 64'd0);
    bus.out_ready_i = 1'b0;

    $display("[TB] test 6: flush then asynchronous reset");
    applyStimulus(1'b1, 1'b1, 40'h7, 3'd3, 64'h0);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 40'h500 + 40'(8 * i), 3'd3, 64'(i));
      stepCycle();
    end
    checkOutput("t6_full", 64'(bus.count_o), 64'd4);
    bus.flush_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 40'h600, 3'd3, 64'h0);
    #1;
    checkOutput("t6_flush_ready", 64'(bus.in_ready_o), 64'd0);
    stepCycle();
    bus.flush_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    checkOutput("t6_flush_count", 64'(bus.count_o), 64'd0);
    checkOutput("t6_flush_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("t6_flush_err", 64'(bus.err_o), 64'd1);
    applyStimulus(1'b1, 1'b1, 40'h700, 3'd3, 64'h77);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 40'h0, 3'd0, 64'h0);
    checkOutput("t6_post_count", 64'(bus.count_o), 64'd1);
    checkOutput("t6_post_addr", 64'(bus.out_addr_o), 64'h700);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("t6_async_count", 64'(bus.count_o), 64'd0);
    checkOutput("t6_async_err", 64'(bus.err_o), 64'd0);
    #10;
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
